mttkrp_adder_tree: RTL and testbench

MTTKRP_ADDER_TREE -- requirements
Module: mttkrp_adder_tree

---
 rtl/mttkrp_pkg.sv | 22 ++
 rtl/mttkrp_sync_fifo.sv | 58 +++++
 rtl/mttkrp_adder_tree.sv | 203 ++++++++++++++++++++
 tb/tb_mttkrp_adder_tree.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mttkrp_pkg.sv
// mttkrp_pkg: definitions shared by the MTTKRP adder tree and its bench.
//   - default parameter constants for the adder tree
//   - mttkrp_state_e: control FSM state encoding (also exported on state_dbg)
//   - mttkrp_row_t  : one factor-matrix row at the default sizes
package mttkrp_pkg;

   localparam int DEF_NUM_PE              = 4;
   localparam int DEF_RANK_FACTOR_MATRIX  = 16;
   localparam int DEF_FACTOR_MATRIX_WIDTH = 32;
   localparam int DEF_ROW_ADDR_WIDTH      = 10;
   localparam int DEF_FIFO_DEPTH          = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } mttkrp_state_e;

   typedef logic [DEF_RANK_FACTOR_MATRIX-1:0][DEF_FACTOR_MATRIX_WIDTH-1:0] mttkrp_row_t;

endpackage

// File: rtl/mttkrp_sync_fifo.sv
// mttkrp_sync_fifo: single-clock FIFO holding reduced rows until downstream
// accepts them. Head entry is shown combinationally on rd_data.
// Ports:
//   clk, rst (async, active-low)
//   wr_en/wr_data : push (ignored when full)
//   rd_en         : pop head (ignored when empty)
//   rd_data       : head entry
//   empty, count  : occupancy
module mttkrp_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = (count == (PW + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage is cleared on reset so the head reads zero afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mttkrp_adder_tree.sv
// mttkrp_adder_tree: element-wise reduction of NUM_PE partial rows per output
// row through a registered binary adder tree, buffered by an output FIFO.
// Optional feature: define MTTKRP_ADDER_SAT_EN for signed saturating adds;
// otherwise adds wrap modulo 2^FACTOR_MATRIX_WIDTH.
// Ports:
//   clk, rst (async, active-low)
//   start, num_rows           : begin a shard of num_rows rows (IDLE only)
//   pe_en, pe_data            : per-PE partial row into lane holding registers
//   ready_to_receive          : registered grant broadcast to all PEs
//   out_valid, out_ready      : output handshake
//   out_row, out_row_addr     : reduced row and its 0-based index in the shard
//   shard_done                : one-cycle pulse when the shard has drained
//   err_overflow              : sticky, pe_en hit an already-full lane
//   state_dbg                 : current FSM state
//
// Handshakes:
//   PE side  - ready_to_receive is a one-cycle grant. Each PE answers a grant
//              with exactly one pe_en cycle, at any later cycle. No further
//              grant is given until every lane has been issued and emptied.
//   Out side - a row transfers on a cycle with out_valid & out_ready; while
//              out_valid & ~out_ready, out_row/out_row_addr are held.
module mttkrp_adder_tree
   import mttkrp_pkg::*;
#(
   parameter int NUM_PE              = DEF_NUM_PE,
   parameter int RANK_FACTOR_MATRIX  = DEF_RANK_FACTOR_MATRIX,
   parameter int FACTOR_MATRIX_WIDTH = DEF_FACTOR_MATRIX_WIDTH,
   parameter int ROW_ADDR_WIDTH      = DEF_ROW_ADDR_WIDTH,
   parameter int FIFO_DEPTH          = DEF_FIFO_DEPTH
) (
   input  logic                                                        clk,
   input  logic                                                        rst,
   input  logic                                                        start,
   input  logic [ROW_ADDR_WIDTH:0]                                     num_rows,
   input  logic [NUM_PE-1:0]                                           pe_en,
   input  logic [NUM_PE-1:0][RANK_FACTOR_MATRIX-1:0][FACTOR_MATRIX_WIDTH-1:0] pe_data,
   output logic                                                        ready_to_receive,
   output logic                                                        out_valid,
   input  logic                                                        out_ready,
   output logic [RANK_FACTOR_MATRIX-1:0][FACTOR_MATRIX_WIDTH-1:0]      out_row,
   output logic [ROW_ADDR_WIDTH-1:0]                                   out_row_addr,
   output logic                                                        shard_done,
   output logic                                                        err_overflow,
   output mttkrp_state_e                                               state_dbg
);
   localparam int EW       = FACTOR_MATRIX_WIDTH;
   localparam int LEVELS   = $clog2(NUM_PE);
   localparam int ROW_BITS = RANK_FACTOR_MATRIX * EW;
   localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

   typedef logic [RANK_FACTOR_MATRIX-1:0][EW-1:0] row_t;

   mttkrp_state_e           state_q;
   logic [ROW_ADDR_WIDTH:0] rows_q;
   logic [ROW_ADDR_WIDTH:0] issued_q;
   logic [ROW_ADDR_WIDTH-1:0] addr_q;
   logic [NUM_PE-1:0]       lane_full;
   row_t                    lane_reg [NUM_PE];
   logic                    grant_pend;
   logic                    issue;
   logic                    ready_d;
   logic                    credit_ok;
   int                      inflight;

   // Heap-ordered tree: node k has children 2k and 2k+1. Nodes 1..NUM_PE-1 are
   // registered sums, nodes NUM_PE..2*NUM_PE-1 are the lane registers. All
   // leaves sit at the same depth, so every path has LEVELS registers.
   row_t                    sum_q [1:NUM_PE-1];
   row_t                    node  [1:2*NUM_PE-1];
   logic [LEVELS-1:0]       valid_sr;

   logic [ROW_BITS-1:0]     fifo_rd_data;
   logic                    fifo_empty;
   logic [CNT_W-1:0]        fifo_count;

   function automatic logic [EW-1:0] add_elem(input logic [EW-1:0] a, input logic [EW-1:0] b);
      logic [EW-1:0] s;
      s = a + b;
`ifdef MTTKRP_ADDER_SAT_EN
      // Same-sign operands producing a different-sign result overflowed.
      if ((a[EW-1] == b[EW-1]) && (s[EW-1] != a[EW-1]))
         s = a[EW-1] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
`endif
      return s;
   endfunction

   function automatic row_t add_row(input row_t a, input row_t b);
      row_t r;
      for (int e = 0; e < RANK_FACTOR_MATRIX; e++) r[e] = add_elem(a[e], b[e]);
      return r;
   endfunction

   always_comb begin
      for (int k = 1; k < NUM_PE; k++) node[k] = sum_q[k];
      for (int p = 0; p < NUM_PE; p++) node[NUM_PE + p] = lane_reg[p];
   end

   always_comb begin
      inflight = 0;
      for (int l = 0; l < LEVELS; l++) inflight = inflight + int'(valid_sr[l]);
   end

   // Two slots of headroom keep space for a row granted but not yet issued.
   assign credit_ok = (int'(fifo_count) + inflight + 2) <= FIFO_DEPTH;
   assign issue     = (state_q == ST_COLLECT) && (&lane_full) && (issued_q < rows_q);
   assign ready_d   = (state_q == ST_COLLECT) && (lane_full == '0) && (pe_en == '0) &&
                      !grant_pend && !ready_to_receive && (issued_q < rows_q) && credit_ok;

   assign out_valid    = !fifo_empty;
   assign out_row      = fifo_rd_data;
   assign out_row_addr = addr_q;
   assign state_dbg    = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 1; k < NUM_PE; k++) sum_q[k] <= '0;
         valid_sr <= '0;
      end else begin
         for (int k = 1; k < NUM_PE; k++) sum_q[k] <= add_row(node[2*k], node[2*k+1]);
         valid_sr[0] <= issue;
         for (int l = 1; l < LEVELS; l++) valid_sr[l] <= valid_sr[l-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= ST_IDLE;
         rows_q           <= '0;
         issued_q         <= '0;
         addr_q           <= '0;
         lane_full        <= '0;
         for (int p = 0; p < NUM_PE; p++) lane_reg[p] <= '0;
         grant_pend       <= 1'b0;
         ready_to_receive <= 1'b0;
         shard_done       <= 1'b0;
         err_overflow     <= 1'b0;
      end else begin
         shard_done       <= 1'b0;
         ready_to_receive <= ready_d;
         if (ready_to_receive) grant_pend <= 1'b1;
         if (issue)            grant_pend <= 1'b0;

         for (int p = 0; p < NUM_PE; p++) begin
            if (pe_en[p]) begin
               if (lane_full[p]) begin
                  err_overflow <= 1'b1;
               end else begin
                  lane_reg[p]  <= pe_data[p];
                  lane_full[p] <= 1'b1;
               end
            end
         end
         // Issue only happens with every lane full, so no lane loads this cycle.
         if (issue) begin
            lane_full <= '0;
            issued_q  <= issued_q + 1'b1;
         end

         if (out_valid && out_ready) addr_q <= addr_q + 1'b1;

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  rows_q   <= num_rows;
                  issued_q <= '0;
                  addr_q   <= '0;
                  if (num_rows == '0) begin
                     state_q    <= ST_DONE;
                     shard_done <= 1'b1;
                  end else begin
                     state_q <= ST_COLLECT;
                  end
               end
            end
            ST_COLLECT: begin
               if (issued_q == rows_q) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if ((valid_sr == '0) && fifo_empty) begin
                  state_q    <= ST_DONE;
                  shard_done <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   mttkrp_sync_fifo #(
      .WIDTH (ROW_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (valid_sr[LEVELS-1]),
      .wr_data (sum_q[1]),
      .rd_en   (out_valid && out_ready),
      .rd_data (fifo_rd_data),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_mttkrp_adder_tree.sv
// tb_mttkrp_adder_tree: directed bench for mttkrp_adder_tree with a
// scoreboard queue filled by the PE driver and drained by an output monitor.
module tb_mttkrp_adder_tree;
   import mttkrp_pkg::*;

   localparam int NUM_PE = 4;
   localparam int R      = 16;
   localparam int W      = 32;
   localparam int AW     = 10;
   localparam int DEPTH  = 8;

   typedef mttkrp_row_t row_t;

   logic                          clk = 1'b0;
   logic                          rst = 1'b0;
   logic                          start = 1'b0;
   logic [AW:0]                   num_rows = '0;
   logic [NUM_PE-1:0]             pe_en = '0;
   logic [NUM_PE-1:0][R-1:0][W-1:0] pe_data = '0;
   logic                          ready_to_receive;
   logic                          out_valid;
   logic                          out_ready = 1'b1;
   row_t                          out_row;
   logic [AW-1:0]                 out_row_addr;
   logic                          shard_done;
   logic                          err_overflow;
   mttkrp_state_e                 state_dbg;

   logic [R*W+AW-1:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int exp_addr = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   mttkrp_adder_tree #(
      .NUM_PE              (NUM_PE),
      .RANK_FACTOR_MATRIX  (R),
      .FACTOR_MATRIX_WIDTH (W),
      .ROW_ADDR_WIDTH      (AW),
      .FIFO_DEPTH          (DEPTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .num_rows         (num_rows),
      .pe_en            (pe_en),
      .pe_data          (pe_data),
      .ready_to_receive (ready_to_receive),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_row          (out_row),
      .out_row_addr     (out_row_addr),
      .shard_done       (shard_done),
      .err_overflow     (err_overflow),
      .state_dbg        (state_dbg)
   );

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [R*W+AW-1:0] e;
      if (rst && out_valid && out_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_row: got addr %0d row %h, none expected", out_row_addr, out_row);
         end else begin
            e = exp_q.pop_front();
            if ({out_row, out_row_addr} !== e) begin
               n_bad++;
               $display("FAIL row_check: got addr %0d row %h, expected addr %0d row %h",
                        out_row_addr, out_row, e[AW-1:0], e[R*W+AW-1:AW]);
            end
         end
      end
      if (rst && shard_done) done_cnt++;
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: PE p sends p+1 in every element            -> sum 10
   // mode 1: PE p sends row+p+1+16*e                    -> sum 4*row+10+64*e
   // mode 2: PEs send 0x7FFFFFFF,1,1,2                  -> 0x80000003 wrapped
   function automatic logic [W-1:0] pe_val(input int mode, input int row, input int p, input int e);
      case (mode)
         0: return W'(p + 1);
         1: return W'(row + p + 1 + 16 * e);
         default: return (p == 0) ? 32'h7FFF_FFFF : ((p == 3) ? 32'd2 : 32'd1);
      endcase
   endfunction

   function automatic logic [W-1:0] exp_val(input int mode, input int row, input int e);
      case (mode)
         0: return 32'd10;
         1: return W'(4 * row + 10 + 64 * e);
`ifdef MTTKRP_ADDER_SAT_EN
         default: return 32'h7FFF_FFFF;
`else
         default: return 32'h8000_0003;
`endif
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic start_shard(input int n);
      num_rows = (AW + 1)'(n);
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic send_row(input int row, input int mode, input int lag, input bit dup0);
      int   dly [NUM_PE];
      int   maxd;
      int   t;
      row_t er;
      for (int p = 0; p < NUM_PE; p++) dly[p] = 1;
      if (lag > 0) dly[2] = lag;
      if (dup0) for (int p = 1; p < NUM_PE; p++) dly[p] = 3;
      maxd = 0;
      for (int p = 0; p < NUM_PE; p++) if (dly[p] > maxd) maxd = dly[p];
      t = 0;
      while (!ready_to_receive && t < 300) begin
         tick();
         t++;
      end
      if (!ready_to_receive) begin
         check("ready_timeout", ready_to_receive, 1);
         return;
      end
      for (int d = 1; d <= maxd; d++) begin
         tick();
         if (lag > 0 && d == lag) begin
            check("lag_ready_low", ready_to_receive, 0);
            if (row == 0) check("lag_no_issue", out_valid, 0);
         end
         for (int p = 0; p < NUM_PE; p++) begin
            pe_en[p] = (dly[p] == d) || (dup0 && p == 0 && d == 2);
            for (int e = 0; e < R; e++)
               pe_data[p][e] = (dup0 && p == 0 && d == 2) ? 32'hDEAD_BEEF : pe_val(mode, row, p, e);
         end
      end
      tick();
      pe_en = '0;
      for (int e = 0; e < R; e++) er[e] = exp_val(mode, row, e);
      exp_q.push_back({er, AW'(exp_addr)});
      exp_addr++;
   endtask

   task automatic wait_done(input int base);
      int t = 0;
      while (done_cnt == base && t < 400) begin
         tick();
         t++;
      end
      repeat (3) tick();
      check("shard_done_once", done_cnt - base, 1);
   endtask

   task automatic run_shard(input int n, input int mode, input int lag, input bit dup0);
      int base;
      base     = done_cnt;
      exp_addr = 0;
      start_shard(n);
      for (int r = 0; r < n; r++) send_row(r, mode, lag, dup0);
      wait_done(base);
   endtask

   task automatic stall_output();
      int   t = 0;
      int   hi = 0;
      row_t r0;
      logic [AW-1:0] a0;
      while (!out_valid && t < 300) begin
         tick();
         t++;
      end
      out_ready = 1'b0;
      r0 = out_row;
      a0 = out_row_addr;
      for (int c = 0; c < 48; c++) begin
         tick();
         if (c >= 36 && ready_to_receive) hi++;
      end
      check("stall_ready_dropped", hi, 0);
      check("stall_valid_held", out_valid, 1);
      check("stall_hold_addr", out_row_addr, a0);
      check("stall_hold_row", (out_row == r0), 1);
      out_ready = 1'b1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int t;
      int base;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ready_to_receive, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_row", (out_row == '0), 1);
      check("rst_out_addr", out_row_addr, 0);
      check("rst_shard_done", shard_done, 0);
      check("rst_err", err_overflow, 0);
      check("rst_state", state_dbg, ST_IDLE);
      rst = 1'b1;
      tick();

      // three rows of 1,2,3,4 -> all elements 10, addrs 0..2
      run_shard(3, 0, 0, 1'b0);
      check("no_err_normal", err_overflow, 0);

      // PE2 five cycles late
      run_shard(2, 1, 5, 1'b0);

      // double pe_en[0] before issue -> sticky overflow, first data kept
      run_shard(1, 0, 0, 1'b1);
      check("err_set", err_overflow, 1);

      // empty shard
      base = done_cnt;
      num_rows = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("zero_rows_done_pulse", shard_done, 1);
      tick();
      check("zero_rows_done_clear", shard_done, 0);
      check("zero_rows_idle", state_dbg, ST_IDLE);
      repeat (3) tick();
      check("zero_rows_done_once", done_cnt - base, 1);

      // overflow / saturation row
      run_shard(1, 2, 0, 1'b0);
      check("err_sticky", err_overflow, 1);

      // 16 rows with downstream stalled
      fork
         run_shard(16, 1, 0, 1'b0);
         stall_output();
      join

      // reset in the middle of collecting
      base = done_cnt;
      start_shard(4);
      t = 0;
      while (!ready_to_receive && t < 300) begin
         tick();
         t++;
      end
      tick();
      pe_en = 4'b0011;
      for (int p = 0; p < NUM_PE; p++)
         for (int e = 0; e < R; e++) pe_data[p][e] = 32'h55;
      tick();
      pe_en = '0;
      #2 rst = 1'b0;
      #1;
      check("midrst_ready", ready_to_receive, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_row", (out_row == '0), 1);
      check("midrst_out_addr", out_row_addr, 0);
      check("midrst_shard_done", shard_done, 0);
      check("midrst_err", err_overflow, 0);
      check("midrst_state", state_dbg, ST_IDLE);
      @(posedge clk);
      #1 rst = 1'b1;
      tick();
      check("midrst_no_done", done_cnt - base, 0);
      run_shard(2, 1, 0, 1'b0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
